// File: rtl/alu_multicycle_sequencer.sv
// alu_multicycle_sequencer: start/done sequencer around the ALU path; ADD/LUI/OR
// finish in one step, SLL/SRL shift one bit per cycle while busy_o stalls fetch.
module alu_multicycle_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LUI = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_SLL = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_result;
  logic [DATA_WIDTH-1:0]  r_work;
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic                   r_dir;
  logic                   r_busy;
  logic                   r_done;
  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic                   w_is_shift;
  logic [DATA_WIDTH-1:0]  w_single;
  logic [DATA_WIDTH-1:0]  w_next_work;
  always_comb begin
    w_shamt     = B_i[SHAMT_WIDTH-1:0];
    w_is_shift  = (ALU_Operation_i == OP_SLL) || (ALU_Operation_i == OP_SRL);
    // A zero-amount shift lands here too and simply passes A through.
    w_single    = (ALU_Operation_i == OP_ADD) ? A_i + B_i :
                  (ALU_Operation_i == OP_LUI) ? B_i :
                  (ALU_Operation_i == OP_OR)  ? A_i | B_i :
                  w_is_shift                  ? A_i : '0;
    w_next_work = r_dir ? r_work >> 1 : r_work << 1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          r_work <= w_next_work;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_WIDTH'(1)) begin
            r_result <= w_next_work;
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          if (start_i && w_is_shift && w_shamt != '0) begin
            r_work  <= A_i;
            r_cnt   <= w_shamt;
            r_dir   <= ALU_Operation_i[0];
            r_state <= SHIFT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else if (start_i) begin
            r_result <= w_single;
            r_state  <= DONE;
            r_done   <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
      endcase
    end
  end
  assign result_o = r_result;
  assign zero_o   = (r_result == '0);
  assign busy_o   = r_busy;
  assign done_o   = r_done;
endmodule
